pcie_link_sequencer: RTL and testbench
======================================

Name: pcie_link_sequencer

Overview:
- Controls the PCIe hard IP reset and link-training sequence on the reconfig/transceiver clock.
- Holds the HIP in reset (hip_npor) after power-up and after host PERST#.
- Releases reset, then watches the LTSSM state for L0 within a timeout.
- On training timeout or a sustained link drop it re-applies reset and retries, up to a bounded retry count. Status goes to the LED/status logic.

Parameters:
- HOLD_CYCLES, 1024, cycles hip_npor is held low after perst_sync goes high (minimum 2).
- TRAIN_TIMEOUT, 33554432, cycles allowed from reset release to L0, excluding cycles frozen in compliance.
- DOWN_FILTER, 256, consecutive non-L0 cycles after a Detect entry before a link drop is declared.
- MAX_RETRY, 3, number of retries before FAIL (1..15).
- CNT_W, 26, width of the shared timer; must hold max(HOLD_CYCLES, TRAIN_TIMEOUT, DOWN_FILTER).

Ports:
- reconfig_xcvr_clk  in  1  sole clock.
- local_rstn  in  1  async active-low reset.
- perstn  in  1  host PERST#; asynchronous to the clock.
- ltssm  in  5  HIP LTSSM state; asynchronous to the clock.
- hip_npor  out  1  HIP npor; 0 = HIP held in reset.
- link_up  out  1  1 while the link is in L0 (state L0).
- link_fail  out  1  1 in FAIL.
- retry_cnt  out  4  retries performed since the last reset/PERST.
- seq_state  out  3  current state encoding.
- comp_active  out  1  1 while ltssm_s == Polling.Compliance (0x03).

Behaviour:
- Interface: one clock, reconfig_xcvr_clk. Reset local_rstn is asynchronous, active-low. All flops and all outputs clear on reset.
- Reset values: hip_npor=0, link_up=0, link_fail=0, retry_cnt=0, seq_state=HOLD, comp_active=0, timer=0, all synchronizer stages=0.
- Synchronizers:
  - perstn goes through 2 flops to give perst_sync.
  - ltssm goes through 2 flops to give ltssm_s. All decisions use ltssm_s, which adds 2 cycles of input latency.
- LTSSM codes: Detect.Quiet=0x00, Detect.Active=0x01, Polling.Compliance=0x03, L0=0x0F.
- Outputs are registered and reflect the state one cycle after a transition (next-state decode into output flops).
- Priority rule: perst_sync==0 overrides everything.
  - Next state is HOLD, timer=0, retry_cnt=0.
  - link_fail clears. Applies from any state, including FAIL.
- States and encodings:
  - HOLD (0):
    - hip_npor=0. Timer increments only while perst_sync==1.
    - At timer==HOLD_CYCLES-1 go to TRAIN and clear timer. hip_npor becomes 1 from the first TRAIN cycle.
  - TRAIN (1):
    - Timer increments each cycle, but holds its value while ltssm_s==0x03.
    - ltssm_s==0x0F: go to L0.
    - Timer==TRAIN_TIMEOUT-1: take the retry path.
    - If both conditions hold in the same cycle, L0 wins.
  - L0 (2):
    - link_up=1.
    - ltssm_s in {0x00, 0x01}: go to DOWN, timer=0.
    - Recovery and other non-Detect states do not leave L0.
  - DOWN (3):
    - link_up=0. Timer increments while ltssm_s != 0x0F.
    - ltssm_s==0x0F before expiry: return to L0, timer=0, no retry counted.
    - Timer==DOWN_FILTER-1: take the retry path.
  - FAIL (4): hip_npor=0, link_fail=1. Exits only via local_rstn or perst_sync low.
- Retry path:
  - If retry_cnt==MAX_RETRY, go to FAIL.
  - Otherwise retry_cnt increments and the state goes to HOLD with timer=0; hip_npor drops the next cycle.
  - retry_cnt is never cleared by reaching L0. It saturates at MAX_RETRY.
- Timer: unsigned CNT_W bits. Cleared on every state change and never wraps, because each state exits before its terminal count.
- Reset mid-operation: asserting local_rstn returns every output to its reset value immediately (asynchronously). The sequence restarts from HOLD after release.
- Encodings 5–7 are unused. The FSM recovers to HOLD from them.

Test Plan (HOLD_CYCLES=8, TRAIN_TIMEOUT=64, DOWN_FILTER=16, MAX_RETRY=2):
- Power-up: release local_rstn with perstn=1, then drive ltssm=0x0F 20 cycles after release.
  - hip_npor rises 8+2 cycles after release (2-flop sync plus 8 hold).
  - link_up=1 exactly 3 cycles after ltssm changes.
  - retry_cnt=0.
- Training timeout: ltssm held at 0x01 throughout.
  - hip_npor drops after 64 TRAIN cycles and retry_cnt goes 1 then 2.
  - After the third timeout: link_fail=1, seq_state=4, hip_npor=0 held indefinitely.
- Compliance freeze: in TRAIN, ltssm=0x03 for 200 cycles, then 0x0F.
  - comp_active=1 during the 0x03 window.
  - No timeout occurs; link_up=1 and retry_cnt=0.
- Link glitch vs drop:
  - From L0, ltssm=0x00 for 10 cycles then 0x0F: seq_state goes 3 then back to 2, retry_cnt unchanged.
  - ltssm=0x00 for 30 cycles: DOWN expires, retry_cnt+1, hip_npor=0 for 8 cycles, then TRAIN.
- PERST override:
  - From FAIL, pulse perstn low for 5 cycles: link_fail=0, retry_cnt=0, seq_state=0; hip_npor rises 8 cycles after perst_sync returns high.
  - Repeating the pulse while in L0 drops link_up 3 cycles after perstn falls.
- Async reset mid-TRAIN: assert local_rstn between clock edges.
  - All outputs reach their reset values without waiting for a clock edge.
  - After release, the sequence replays the power-up timing.

Source files
------------

// File: rtl/pcie_link_sequencer.sv
// PCIe hard-IP reset / link-training sequencer.
// Holds the HIP in reset after power-up or host PERST#, releases it, and
// waits for the LTSSM to reach L0. A training timeout or a sustained link
// drop re-applies reset and retries. When the retries are used up the
// sequencer parks in FAIL until PERST# or local reset.
module pcie_link_sequencer #(
  parameter int HOLD_CYCLES   = 1024,
  parameter int TRAIN_TIMEOUT = 33554432,
  parameter int DOWN_FILTER   = 256,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 26
) (
  input  logic       reconfig_xcvr_clk,
  input  logic       local_rstn,
  input  logic       perstn,
  input  logic [4:0] ltssm,
  output logic       hip_npor,
  output logic       link_up,
  output logic       link_fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] seq_state,
  output logic       comp_active
);

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_TRAIN = 3'd1,
    S_L0    = 3'd2,
    S_DOWN  = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  localparam logic [4:0] LT_DQUIET  = 5'h00;
  localparam logic [4:0] LT_DACTIVE = 5'h01;
  localparam logic [4:0] LT_COMP    = 5'h03;
  localparam logic [4:0] LT_L0      = 5'h0F;

  // Terminal counts: each state leaves on the cycle the timer shows TC,
  // so the timer never needs to wrap.
  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRAIN_TC = CNT_W'(TRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DOWN_TC  = CNT_W'(DOWN_FILTER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

  logic       perst_s1, perst_sync;
  logic [4:0] ltssm_s1, ltssm_s;

  state_t           state, nxt_state;
  logic [CNT_W-1:0] timer, nxt_timer;
  logic [3:0]       nxt_retry;
  logic             take_retry;

  // Two-flop synchronizers for PERST# and LTSSM; comp_active is decoded from
  // the first stage so it lines up exactly with ltssm_s.
  always_ff @(posedge reconfig_xcvr_clk or negedge local_rstn) begin
    if (!local_rstn) begin
      perst_s1    <= 1'b0;
      perst_sync  <= 1'b0;
      ltssm_s1    <= 5'h00;
      ltssm_s     <= 5'h00;
      comp_active <= 1'b0;
    end else begin
      perst_s1    <= perstn;
      perst_sync  <= perst_s1;
      ltssm_s1    <= ltssm;
      ltssm_s     <= ltssm_s1;
      comp_active <= (ltssm_s1 == LT_COMP);
    end
  end

  // Next-state, timer and retry decode; PERST low beats everything.
  always_comb begin
    nxt_state  = state;
    nxt_timer  = timer;
    nxt_retry  = retry_cnt;
    take_retry = 1'b0;
    if (!perst_sync) begin
      nxt_state = S_HOLD;
      nxt_timer = '0;
      nxt_retry = '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (timer == HOLD_TC) begin
            nxt_state = S_TRAIN;
            nxt_timer = '0;
          end else begin
            nxt_timer = timer + CNT_ONE;
          end
        end
        S_TRAIN: begin
          // L0 wins over a simultaneous timeout; compliance freezes the timer.
          if (ltssm_s == LT_L0) begin
            nxt_state = S_L0;
            nxt_timer = '0;
          end else if (timer == TRAIN_TC) begin
            take_retry = 1'b1;
          end else if (ltssm_s != LT_COMP) begin
            nxt_timer = timer + CNT_ONE;
          end
        end
        S_L0: begin
          // Only a Detect entry counts as a potential drop; Recovery stays.
          nxt_timer = '0;
          if (ltssm_s == LT_DQUIET || ltssm_s == LT_DACTIVE) nxt_state = S_DOWN;
        end
        S_DOWN: begin
          if (ltssm_s == LT_L0) begin
            nxt_state = S_L0;
            nxt_timer = '0;
          end else if (timer == DOWN_TC) begin
            take_retry = 1'b1;
          end else begin
            nxt_timer = timer + CNT_ONE;
          end
        end
        S_FAIL: nxt_timer = '0;
        default: begin
          nxt_state = S_HOLD;
          nxt_timer = '0;
        end
      endcase
      if (take_retry) begin
        nxt_timer = '0;
        if (retry_cnt == RETRY_MAX) begin
          nxt_state = S_FAIL;
        end else begin
          nxt_state = S_HOLD;
          nxt_retry = retry_cnt + 4'd1;
        end
      end
    end
  end

  // State, timer and registered outputs decoded from the next state.
  always_ff @(posedge reconfig_xcvr_clk or negedge local_rstn) begin
    if (!local_rstn) begin
      state     <= S_HOLD;
      timer     <= '0;
      retry_cnt <= 4'd0;
      seq_state <= S_HOLD;
      hip_npor  <= 1'b0;
      link_up   <= 1'b0;
      link_fail <= 1'b0;
    end else begin
      state     <= nxt_state;
      timer     <= nxt_timer;
      retry_cnt <= nxt_retry;
      seq_state <= nxt_state;
      hip_npor  <= (nxt_state == S_TRAIN) || (nxt_state == S_L0) || (nxt_state == S_DOWN);
      link_up   <= (nxt_state == S_L0);
      link_fail <= (nxt_state == S_FAIL);
    end
  end

endmodule

// File: tb/tb_pcie_link_sequencer.sv
// Bench for pcie_link_sequencer: directed milestones with fixed expected
// cycle counts, then randomized LTSSM/PERST/reset traffic, with every cycle
// compared against a behavioural model of the sequencing rules.
module tb_pcie_link_sequencer;
  localparam int H  = 8;
  localparam int T  = 64;
  localparam int D  = 16;
  localparam int MR = 2;
  localparam int CW = 8;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b1;
  logic       perstn = 1'b1;
  logic [4:0] ltssm = 5'h00;
  logic       hip_npor, link_up, link_fail, comp_active;
  logic [3:0] retry_cnt;
  logic [2:0] seq_state;

  int ncmp = 0;
  int nerr = 0;

  // Model: mode uses the published state numbers (0 HOLD .. 4 FAIL),
  // cnt is cycles elapsed in the current phase.
  int         m_mode, m_cnt, m_retry;
  logic       m_p1, m_p2;
  logic [4:0] m_l1, m_l2;

  always #5 clk = ~clk;

  pcie_link_sequencer #(
    .HOLD_CYCLES(H), .TRAIN_TIMEOUT(T), .DOWN_FILTER(D), .MAX_RETRY(MR), .CNT_W(CW)
  ) dut (
    .reconfig_xcvr_clk(clk),
    .local_rstn(rstn),
    .perstn(perstn),
    .ltssm(ltssm),
    .hip_npor(hip_npor),
    .link_up(link_up),
    .link_fail(link_fail),
    .retry_cnt(retry_cnt),
    .seq_state(seq_state),
    .comp_active(comp_active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_retry = 0;
    m_p1 = 1'b0; m_p2 = 1'b0; m_l1 = 5'h00; m_l2 = 5'h00;
  endtask

  task automatic model_retry();
    m_cnt = 0;
    if (m_retry == MR) m_mode = 4;
    else begin
      m_retry++;
      m_mode = 0;
    end
  endtask

  task automatic model_tick();
    if (!m_p2) begin
      m_mode = 0; m_cnt = 0; m_retry = 0;
    end else begin
      case (m_mode)
        0: if (m_cnt == H - 1) begin m_mode = 1; m_cnt = 0; end else m_cnt++;
        1: if (m_l2 == 5'h0F) begin m_mode = 2; m_cnt = 0; end
           else if (m_cnt == T - 1) model_retry();
           else if (m_l2 != 5'h03) m_cnt++;
        2: if (m_l2 <= 5'h01) begin m_mode = 3; m_cnt = 0; end
        3: if (m_l2 == 5'h0F) begin m_mode = 2; m_cnt = 0; end
           else if (m_cnt == D - 1) model_retry();
           else m_cnt++;
        default: ;
      endcase
    end
    m_p2 = m_p1; m_p1 = perstn;
    m_l2 = m_l1; m_l1 = ltssm;
  endtask

  task automatic check_all();
    chk("seq_state", seq_state, m_mode);
    chk("hip_npor", hip_npor, (m_mode >= 1 && m_mode <= 3));
    chk("link_up", link_up, (m_mode == 2));
    chk("link_fail", link_fail, (m_mode == 4));
    chk("retry_cnt", retry_cnt, m_retry);
    chk("comp_active", comp_active, (m_l2 == 5'h03));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rstn) model_reset();
    else model_tick();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int rise, fall, cyc, plow;
    model_reset();
    #2 rstn = 1'b0;
    steps(3);
    chk("rst_hip_npor", hip_npor, 0);
    chk("rst_seq_state", seq_state, 0);
    chk("rst_retry", retry_cnt, 0);

    // Power-up: npor after 2 sync + 8 hold, L0 three cycles after ltssm.
    rstn = 1'b1;
    rise = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (rise < 0 && hip_npor) rise = i;
    end
    chk("pwrup_npor_rise", rise, 10);
    ltssm = 5'h0F;
    rise = -1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (rise < 0 && link_up) rise = i;
    end
    chk("pwrup_l0_latency", rise, 3);
    chk("pwrup_retry", retry_cnt, 0);

    // Short Detect glitch is filtered.
    ltssm = 5'h00;
    steps(10);
    chk("glitch_in_down", seq_state, 3);
    ltssm = 5'h0F;
    steps(3);
    chk("glitch_back_l0", seq_state, 2);
    chk("glitch_retry", retry_cnt, 0);

    // PERST while in L0, then compliance freeze during the next TRAIN.
    perstn = 1'b0;
    fall = -1;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (fall < 0 && !link_up) fall = i;
    end
    chk("perst_linkup_drop", fall, 3);
    ltssm = 5'h03;
    perstn = 1'b1;
    rise = -1;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (rise < 0 && hip_npor) rise = i;
    end
    chk("perst_npor_rise", rise, 10);
    steps(185);
    chk("comp_active_win", comp_active, 1);
    chk("comp_still_train", seq_state, 1);
    ltssm = 5'h0F;
    steps(3);
    chk("comp_then_l0", link_up, 1);
    chk("comp_retry", retry_cnt, 0);

    // Sustained drop: retry, then training timeouts until FAIL.
    ltssm = 5'h00;
    rise = -1; fall = -1; cyc = -1;
    for (int i = 1; i <= 300 && cyc < 0; i++) begin
      step();
      if (i == 30) ltssm = 5'h01;
      if (fall < 0 && !hip_npor) fall = i;
      if (fall > 0 && rise < 0 && hip_npor) rise = i;
      if (link_fail) cyc = i;
    end
    chk("drop_npor_fall", fall, 19);
    chk("drop_npor_rise", rise, 27);
    chk("fail_cycle", cyc, 163);
    chk("fail_state", seq_state, 4);
    chk("fail_retry", retry_cnt, MR);
    steps(50);
    chk("fail_held", link_fail, 1);
    chk("fail_npor_low", hip_npor, 0);

    // PERST clears FAIL.
    perstn = 1'b0;
    steps(5);
    chk("perst_clr_fail", link_fail, 0);
    chk("perst_clr_retry", retry_cnt, 0);
    chk("perst_clr_state", seq_state, 0);
    perstn = 1'b1;
    rise = -1;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (rise < 0 && hip_npor) rise = i;
    end
    chk("fail_exit_npor_rise", rise, 10);

    // Asynchronous reset in the middle of TRAIN, no clock edge needed.
    #3 rstn = 1'b0;
    model_reset();
    #1;
    chk("async_npor", hip_npor, 0);
    chk("async_state", seq_state, 0);
    check_all();
    steps(2);
    rstn = 1'b1;
    rise = -1;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (rise < 0 && hip_npor) rise = i;
    end
    chk("replay_npor_rise", rise, 10);

    // Randomized traffic checked cycle by cycle against the model.
    plow = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 5))
          0: ltssm = 5'h00;
          1: ltssm = 5'h01;
          2: ltssm = 5'h03;
          3, 4: ltssm = 5'h0F;
          default: ltssm = 5'($urandom_range(0, 31));
        endcase
      end
      if (plow == 0 && $urandom_range(0, 399) == 0) plow = $urandom_range(1, 8);
      perstn = (plow == 0);
      if (plow > 0) plow--;
      if ($urandom_range(0, 1499) == 0) begin
        #3 rstn = 1'b0;
        model_reset();
        #1;
        check_all();
        #1 rstn = 1'b1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
